// File: rtl/ccd_avg_acq.sv
// Multi-scan CCD acquisition: accumulates 2^k scans per pixel in RAM, then clamps,
// subtracts the offset and queues the averaged pixels in a show-ahead output FIFO.
module ccd_avg_acq #(
    parameter int PIX_W     = 16,
    parameter int NPIX      = 2048,
    parameter int ADDR_W    = 11,
    parameter int AVG_LW    = 3,
    parameter int OUT_DEPTH = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [AVG_LW-1:0] cfg_avg_log2,
    input  logic [PIX_W-1:0]  cfg_offset,
    input  logic [PIX_W-1:0]  cfg_maxsat,
    input  logic              trigger,
    input  logic              abort,
    output logic              scan_start,
    input  logic              s_valid,
    input  logic [PIX_W-1:0]  s_data,
    output logic              m_valid,
    output logic [PIX_W-1:0]  m_data,
    input  logic              m_ready,
    output logic              pixel_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              ovf,
    output logic [ADDR_W:0]   sat_cnt
);

    localparam int SCAN_W = (1 << AVG_LW) - 1;
    localparam int ACC_W  = PIX_W + SCAN_W;
    localparam int FA     = $clog2(OUT_DEPTH);
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NPIX - 1);
    localparam logic [FA:0]       CNT_FULL = (FA + 1)'(OUT_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_SCAN, S_FLUSH} state_t;

    function automatic logic [PIX_W-1:0] clamp_avg(input logic [ACC_W-1:0] avg,
                                                   input logic [PIX_W-1:0] ceil_v);
        return (avg > ACC_W'(ceil_v)) ? ceil_v : avg[PIX_W-1:0];
    endfunction

    function automatic logic [PIX_W-1:0] sub_floor(input logic [PIX_W-1:0] val,
                                                   input logic [PIX_W-1:0] off);
        return (val > off) ? val - off : '0;
    endfunction

    state_t              state_q, state_d;
    logic                trg_q;
    logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic                flush_cnt_q, flush_cnt_d;
    logic [AVG_LW-1:0]   k_q, k_d;
    logic [PIX_W-1:0]    off_q, off_d, max_q, max_d;
    logic                ovf_q, ovf_d;
    logic [ADDR_W:0]     sat_cnt_q, sat_cnt_d;

    logic                vld_p0_q, fin_p0_q, first_p0_q;
    logic [PIX_W-1:0]    smp_p0_q;
    logic [ADDR_W-1:0]   addr_p0_q;
    logic [ACC_W-1:0]    rd_data_q;
    logic                vld_p1_q;
    logic [ACC_W-1:0]    sum_p1_q, sum_d;

    logic [ACC_W-1:0]    acc_mem [NPIX];
    logic [PIX_W-1:0]    fifo_mem [OUT_DEPTH];
    logic [FA-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FA:0]         cnt_q, cnt_d;

    logic                trig_rise, take, fifo_flush, push, push_ok, pop, fifo_full;
    logic                acc_we, sat_hit;
    logic [SCAN_W:0]     one_sh;
    logic [SCAN_W-1:0]   scan_max;
    logic [ACC_W-1:0]    avg_p1;
    logic [PIX_W-1:0]    pix_val;

    assign trig_rise   = trigger & ~trg_q;
    assign one_sh      = (SCAN_W + 1)'(1) << k_q;
    assign scan_max    = SCAN_W'(one_sh - 1'b1);
    assign busy        = (state_q != S_IDLE);
    assign m_valid     = (cnt_q != '0);
    assign pixel_ready = m_valid;
    assign m_data      = m_valid ? fifo_mem[rd_ptr_q] : '0;
    assign ovf         = ovf_q;
    assign sat_cnt     = sat_cnt_q;
    assign fifo_full   = (cnt_q == CNT_FULL);
    assign pop         = m_valid & m_ready;

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        scan_cnt_d  = scan_cnt_q;
        flush_cnt_d = flush_cnt_q;
        k_d         = k_q;
        off_d       = off_q;
        max_d       = max_q;
        ovf_d       = ovf_q;
        sat_cnt_d   = sat_cnt_q;
        fifo_flush  = 1'b0;
        take        = 1'b0;
        frame_done  = 1'b0;
        scan_start  = (state_q == S_START);
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        if (push && sat_hit) sat_cnt_d = sat_cnt_q + 1'b1;
        if (abort) begin
            state_d    = S_IDLE;
            fifo_flush = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trig_rise) begin
                        state_d    = S_START;
                        k_d        = cfg_avg_log2;
                        off_d      = cfg_offset;
                        max_d      = cfg_maxsat;
                        pix_cnt_d  = '0;
                        scan_cnt_d = '0;
                        ovf_d      = 1'b0;
                        sat_cnt_d  = '0;
                        fifo_flush = 1'b1;
                    end
                end
                S_START: state_d = S_SCAN;
                S_SCAN: begin
                    if (s_valid) begin
                        take = 1'b1;
                        if (pix_cnt_q == PIX_LAST) begin
                            pix_cnt_d = '0;
                            if (scan_cnt_q != scan_max) begin
                                scan_cnt_d = scan_cnt_q + 1'b1;
                                state_d    = S_START;
                            end else begin
                                flush_cnt_d = 1'b0;
                                state_d     = S_FLUSH;
                            end
                        end else begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q) begin
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        flush_cnt_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // stage p0 -> p1: read-modify-write; scan 0 overwrites stale RAM contents
    always_comb begin
        sum_d  = first_p0_q ? ACC_W'(smp_p0_q) : rd_data_q + ACC_W'(smp_p0_q);
        acc_we = vld_p0_q & ~fin_p0_q;
    end

    // stage p1 -> FIFO: average, clamp, offset
    always_comb begin
        avg_p1  = sum_p1_q >> k_q;
        sat_hit = (avg_p1 > ACC_W'(max_q));
        pix_val = sub_floor(clamp_avg(avg_p1, max_q), off_q);
        push    = vld_p1_q & ~abort;
        push_ok = push & (~fifo_full | pop);
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok && !pop) cnt_d = cnt_q + 1'b1;
        if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
        if (fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q     <= S_IDLE;
            trg_q       <= 1'b0;
            pix_cnt_q   <= '0;
            scan_cnt_q  <= '0;
            flush_cnt_q <= 1'b0;
            ovf_q       <= 1'b0;
            sat_cnt_q   <= '0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            trg_q       <= trigger;
            pix_cnt_q   <= pix_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            ovf_q       <= ovf_d;
            sat_cnt_q   <= sat_cnt_d;
            vld_p0_q    <= take;
            vld_p1_q    <= vld_p0_q & fin_p0_q & ~abort;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        k_q        <= k_d;
        off_q      <= off_d;
        max_q      <= max_d;
        smp_p0_q   <= s_data;
        addr_p0_q  <= pix_cnt_q;
        fin_p0_q   <= (scan_cnt_q == scan_max);
        first_p0_q <= (scan_cnt_q == '0);
        rd_data_q  <= acc_mem[pix_cnt_q];
        sum_p1_q   <= sum_d;
        if (acc_we) acc_mem[addr_p0_q] <= sum_d;
        if (push_ok) fifo_mem[wr_ptr_q] <= pix_val;
    end

endmodule

// File: tb/tb_ccd_avg_acq.sv
// Bench for ccd_avg_acq: frames are modelled as per-pixel sums over scans, expected pixels
// are queued when a frame is issued and a forked monitor compares every popped pixel.
module tb_ccd_avg_acq;
    localparam int PIX_W = 16, NPIX = 32, ADDR_W = 5, AVG_LW = 3, DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              sys_rst, trigger, abort, s_valid, m_ready;
    logic [AVG_LW-1:0] cfg_avg_log2;
    logic [PIX_W-1:0]  cfg_offset, cfg_maxsat, s_data, m_data;
    logic              scan_start, m_valid, pixel_ready, busy, frame_done, ovf;
    logic [ADDR_W:0]   sat_cnt;

    ccd_avg_acq #(.PIX_W(PIX_W), .NPIX(NPIX), .ADDR_W(ADDR_W), .AVG_LW(AVG_LW),
                  .OUT_DEPTH(DEPTH)) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .cfg_avg_log2(cfg_avg_log2),
        .cfg_offset(cfg_offset), .cfg_maxsat(cfg_maxsat), .trigger(trigger),
        .abort(abort), .scan_start(scan_start), .s_valid(s_valid), .s_data(s_data),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .pixel_ready(pixel_ready), .busy(busy), .frame_done(frame_done), .ovf(ovf),
        .sat_cnt(sat_cnt)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    int sc_cnt = 0, fd_cnt = 0;
    int first_smp_cyc = 0, first_mv_cyc = -1;
    bit mv_armed = 1'b0;
    logic [PIX_W-1:0] exp_q[$];
    logic [PIX_W-1:0] smp [8][NPIX];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic mon_step();
        logic [PIX_W-1:0] e;
        if (scan_start) sc_cnt++;
        if (frame_done) fd_cnt++;
        if (mv_armed && m_valid) begin
            first_mv_cyc = cyc;
            mv_armed = 1'b0;
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pixel: got %0d, expected no pixel", m_data);
            end else begin
                e = exp_q.pop_front();
                chk("pixel", m_data, e);
                chk("pixel_ready", pixel_ready, 1);
            end
        end
    endtask

    // Reference: per-pixel sum over all scans, then shift, clamp, offset with floor.
    task automatic model_frame(input int k, input int off, input int mx, input int limit,
                               output int nsat);
        longint sum, avg, c, v;
        nsat = 0;
        for (int p = 0; p < NPIX; p++) begin
            sum = 0;
            for (int s = 0; s < (1 << k); s++) sum += smp[s][p];
            avg = sum >> k;
            if (avg > mx) begin
                nsat++;
                c = mx;
            end else begin
                c = avg;
            end
            v = (c > off) ? c - off : 0;
            if (p < limit) exp_q.push_back(PIX_W'(v));
        end
    endtask

    task automatic do_frame(input int k, input int off, input int mx, input int abort_at,
                            input bit noise, input bit gaps);
        int nscan, sc0, fd0, exp_sat;
        nscan = 1 << k;
        sc0 = sc_cnt;
        fd0 = fd_cnt;
        exp_sat = 0;
        if (abort_at < 0) model_frame(k, off, mx, m_ready ? NPIX : DEPTH, exp_sat);
        cfg_avg_log2 = AVG_LW'(k);
        cfg_offset = PIX_W'(off);
        cfg_maxsat = PIX_W'(mx);
        if (noise) begin
            s_valid = 1'b1;
            repeat (3) begin
                s_data = PIX_W'($urandom);
                tick();
            end
            s_valid = 1'b0;
        end
        trigger = 1'b1;
        tick();
        chk("busy_after_trigger", busy, 1);
        chk("scan_start_after_trigger", scan_start, 1);
        trigger = 1'b0;
        cfg_avg_log2 = AVG_LW'($urandom);
        cfg_offset = PIX_W'($urandom);
        cfg_maxsat = PIX_W'($urandom);
        for (int s = 0; s < nscan; s++) begin
            for (int w = 0; w < 64 && !scan_start; w++) tick();
            if (!scan_start) begin
                chk("scan_start_timeout", 0, 1);
                return;
            end
            tick();
            for (int p = 0; p < NPIX; p++) begin
                if (gaps && $urandom_range(3) == 0) begin
                    s_valid = 1'b0;
                    tick();
                end
                s_valid = 1'b1;
                s_data = smp[s][p];
                if (s == 0 && p == 0) begin
                    first_smp_cyc = cyc;
                    mv_armed = 1'b1;
                end
                if (noise) trigger = (s == 0 && p >= 4 && p < 7);
                if (s == 1 && p == abort_at) abort = 1'b1;
                tick();
                if (abort) begin
                    abort = 1'b0;
                    s_valid = 1'b0;
                    chk("busy_after_abort", busy, 0);
                    chk("m_valid_after_abort", m_valid, 0);
                    repeat (6) tick();
                    chk("frame_done_after_abort", fd_cnt - fd0, 0);
                    chk("idle_after_abort", busy, 0);
                    return;
                end
            end
            s_valid = 1'b0;
        end
        for (int w = 0; w < 16 && busy; w++) tick();
        chk("busy_end", busy, 0);
        repeat (4) tick();
        chk("frame_done_count", fd_cnt - fd0, 1);
        chk("scan_start_count", sc_cnt - sc0, nscan);
        chk("sat_cnt", sat_cnt, exp_sat);
        chk("ovf", ovf, m_ready ? 0 : 1);
        if (m_ready) chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        sys_rst = 1'b0; trigger = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        m_ready = 1'b1; cfg_avg_log2 = '0; cfg_offset = '0; cfg_maxsat = '0;
        repeat (3) tick();
        chk("rst_scan_start", scan_start, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_pixel_ready", pixel_ready, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        sys_rst = 1'b1;
        repeat (2) tick();

        // single scan, ramp, pass-through
        for (int p = 0; p < NPIX; p++) smp[0][p] = PIX_W'(p + 1);
        do_frame(0, 0, 16'hFFFF, -1, 1'b0, 1'b0);
        chk("first_m_valid_latency", first_mv_cyc - first_smp_cyc, 3);

        // four scans of constants 100..103
        for (int s = 0; s < 4; s++)
            for (int p = 0; p < NPIX; p++) smp[s][p] = PIX_W'(100 + s);
        do_frame(2, 0, 16'hFFFF, -1, 1'b0, 1'b0);

        // saturation then offset floor
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < NPIX; p++) smp[s][p] = 16'd1000;
        do_frame(1, 50, 500, -1, 1'b0, 1'b1);
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < NPIX; p++) smp[s][p] = 16'd40;
        do_frame(1, 50, 500, -1, 1'b0, 1'b0);

        // output FIFO overflow with the reader stalled
        for (int p = 0; p < NPIX; p++) smp[0][p] = PIX_W'($urandom);
        m_ready = 1'b0;
        do_frame(0, 0, 16'hFFFF, -1, 1'b0, 1'b0);
        chk("ovf_m_valid_held", m_valid, 1);
        m_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        chk("ovf_queue_drained", exp_q.size(), 0);
        chk("ovf_m_valid_empty", m_valid, 0);

        // abort mid final scan, then a clean frame over stale RAM
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < NPIX; p++) smp[s][p] = PIX_W'($urandom_range(60000, 65535));
        m_ready = 1'b0;
        do_frame(1, 0, 16'hFFFF, 10, 1'b0, 1'b0);
        m_ready = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < NPIX; p++) smp[s][p] = PIX_W'($urandom_range(0, 999));
        do_frame(1, 7, 16'hFFFF, -1, 1'b0, 1'b0);

        // IDLE samples and a trigger edge while busy are ignored
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < NPIX; p++) smp[s][p] = PIX_W'($urandom);
        do_frame(1, 300, 40000, -1, 1'b1, 1'b1);

        // randomized frames
        for (int f = 0; f < 4; f++) begin
            int k, off, mx;
            k = $urandom_range(0, 3);
            off = $urandom_range(0, 2000);
            mx = ($urandom_range(0, 1) == 0) ? 16'hFFFF : $urandom_range(20000, 65535);
            for (int s = 0; s < (1 << k); s++)
                for (int p = 0; p < NPIX; p++) smp[s][p] = PIX_W'($urandom);
            do_frame(k, off, mx, -1, 1'b0, 1'b1);
        end

        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
